// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared encodings for the byte-wide RAM port controller.
//   ctrl_state_e : controller FSM states (IDLE / READ / WRITE)
//   owner_e      : which pipeline stage owns the RAM port
//   SIZE_*       : access size encodings on mem_size_i (2'b11 behaves as word)
//   RD_LATENCY   : cycles from ram_addr_o to valid ram_din_i
//   size_len()   : access size -> byte count
//   load_extend(): sign/zero extension of an assembled load

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_READ  = 2'd1,
        CTRL_WRITE = 2'd2
    } ctrl_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int RD_LATENCY = 1;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            SIZE_B:  return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SIZE_H:  return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if -- bundle of every mem_ctrl signal except clk/rst.
//   IF port  : if_req_i, if_addr_i, if_flush_i -> if_done_o, if_data_o
//   MEM port : mem_req_i, mem_we_i, mem_size_i, mem_unsigned_i, mem_addr_i,
//              mem_wdata_i -> mem_done_o, mem_rdata_o
//   RAM port : ram_addr_o, ram_we_o, ram_dout_o <- ram_din_i
//   Debug    : state_o, the controller FSM state
// Handshake: a requester raises req_i with stable operands and keeps it high
// until it sees its one-cycle done_o pulse; the transfer completes in exactly
// that cycle and done_o never fires without a preceding accepted req_i.
// Modport slave is the controller; master is the pipeline + RAM side.

interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    import mem_ctrl_pkg::*;

    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_flush_i;
    logic                  if_done_o;
    logic [31:0]           if_data_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [1:0]            mem_size_i;
    logic                  mem_unsigned_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [31:0]           mem_wdata_i;
    logic                  mem_done_o;
    logic [31:0]           mem_rdata_o;

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_we_o;
    logic [7:0]            ram_dout_o;
    logic [7:0]            ram_din_i;

    ctrl_state_e           state_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_data_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_unsigned_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output ram_addr_o, ram_we_o, ram_dout_o,
        input  ram_din_i,
        output state_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_data_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_unsigned_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  ram_addr_o, ram_we_o, ram_dout_o,
        output ram_din_i,
        input  state_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl -- serializes 1/2/4-byte accesses onto a byte-wide RAM and
// arbitrates that single port between instruction fetch and the MEM stage.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_ctrl_if.slave (IF port, MEM port, RAM port, debug state)
// MEM requests win over IF in IDLE; an accepted transaction runs to the end
// (except an IF fetch abandoned by if_flush_i). All outputs are registered.

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    ctrl_state_e           state_q;
    owner_e                owner_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [2:0]            len_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [2:0]            iss_q;     // next byte index to put on the address bus
    logic [2:0]            cap_q;     // next byte lane to capture
    logic [1:0]            lat_q;     // remaining cycles before the first read byte arrives
    logic [31:0]           asm_q;
    logic [31:0]           wdata_q;

    logic                  if_done_q;
    logic [31:0]           if_data_q;
    logic                  mem_done_q;
    logic [31:0]           mem_rdata_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_we_q;
    logic [7:0]            ram_dout_q;

    logic                  mem_cand;
    logic                  if_cand;
    logic [31:0]           asm_d;

    // A requester still holding req_i during its own done cycle is finished,
    // not asking again.
    assign mem_cand = bus.mem_req_i && !mem_done_q;
    assign if_cand  = bus.if_req_i && !if_done_q && !bus.if_flush_i;

    // Buffer lanes fill in order and start cleared, so OR-ing the new byte in
    // is enough.
    always_comb begin
        asm_d = asm_q | (32'(bus.ram_din_i) << {cap_q[1:0], 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_IDLE;
            owner_q     <= OWNER_IF;
            base_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            iss_q       <= '0;
            cap_q       <= '0;
            lat_q       <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_dout_q  <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;

            case (state_q)
                CTRL_IDLE: begin
                    ram_we_q <= 1'b0;
                    iss_q    <= 3'd1;
                    cap_q    <= '0;
                    lat_q    <= 2'(RD_LATENCY);
                    asm_q    <= '0;
                    if (mem_cand) begin
                        owner_q    <= OWNER_MEM;
                        base_q     <= bus.mem_addr_i;
                        len_q      <= size_len(bus.mem_size_i);
                        size_q     <= bus.mem_size_i;
                        uns_q      <= bus.mem_unsigned_i;
                        wdata_q    <= bus.mem_wdata_i;
                        ram_addr_q <= bus.mem_addr_i;
                        if (bus.mem_we_i) begin
                            ram_we_q   <= 1'b1;
                            ram_dout_q <= bus.mem_wdata_i[7:0];
                            state_q    <= CTRL_WRITE;
                        end else begin
                            state_q    <= CTRL_READ;
                        end
                    end else if (if_cand) begin
                        owner_q    <= OWNER_IF;
                        base_q     <= bus.if_addr_i;
                        len_q      <= 3'd4;
                        size_q     <= SIZE_W;
                        uns_q      <= 1'b1;
                        ram_addr_q <= bus.if_addr_i;
                        state_q    <= CTRL_READ;
                    end
                end

                CTRL_READ: begin
                    if (owner_q == OWNER_IF && bus.if_flush_i) begin
                        // Abandoned fetch: captured bytes are simply discarded.
                        state_q <= CTRL_IDLE;
                    end else begin
                        if (iss_q < len_q) begin
                            ram_addr_q <= base_q + ADDR_WIDTH'(iss_q);
                            iss_q      <= iss_q + 3'd1;
                        end
                        if (lat_q != 2'd0) begin
                            lat_q <= lat_q - 2'd1;
                        end else begin
                            asm_q <= asm_d;
                            cap_q <= cap_q + 3'd1;
                            if (cap_q == len_q - 3'd1) begin
                                state_q <= CTRL_IDLE;
                                if (owner_q == OWNER_MEM) begin
                                    mem_done_q  <= 1'b1;
                                    mem_rdata_q <= load_extend(asm_d, size_q, uns_q);
                                end else begin
                                    if_done_q <= 1'b1;
                                    if_data_q <= asm_d;
                                end
                            end
                        end
                    end
                end

                CTRL_WRITE: begin
                    if (iss_q < len_q) begin
                        ram_addr_q <= base_q + ADDR_WIDTH'(iss_q);
                        ram_dout_q <= 8'(wdata_q >> {iss_q[1:0], 3'b000});
                        ram_we_q   <= 1'b1;
                        iss_q      <= iss_q + 3'd1;
                    end else begin
                        ram_we_q   <= 1'b0;
                        mem_done_q <= 1'b1;
                        state_q    <= CTRL_IDLE;
                    end
                end

                default: begin
                    ram_we_q <= 1'b0;
                    state_q  <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign bus.if_done_o   = if_done_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- self-checking bench for mem_ctrl: byte RAM model, table of
// directed accesses, hand-written multi-cycle sequences (arbitration, flush,
// reset mid-store) and randomized traffic against a byte-array reference.

module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk;
    logic rst;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [7:0]  ram [0:1023];
    logic        pre_clr;
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [7:0]  pre_data;
    logic [39:0] wr_log[$];

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
        if (bus.ram_we_o) begin
            ram[bus.ram_addr_o[9:0]] <= bus.ram_dout_o;
            wr_log.push_back({bus.ram_addr_o, bus.ram_dout_o});
        end
        bus.ram_din_i <= ram[bus.ram_addr_o[9:0]];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  model_mem [0:1023];
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian gather, then two's-complement extension by arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] addr,
                                               input logic [1:0] size,
                                               input logic uns);
        longint unsigned v = 0;
        logic [31:0] a;
        int n = nbytes(size);
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v + (longint'(model_mem[a[9:0]]) << (8 * k));
        end
        if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = addr[9:0];
        pre_data = data;
        model_mem[addr[9:0]] = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Expected store traffic: one byte per address, low byte first.
    task automatic check_store(input string name, input logic [31:0] addr,
                               input int n, input logic [31:0] wdata, input int start);
        logic [31:0] a;
        logic [39:0] e;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            exp_q.push_back({a, 8'((wdata >> (8 * k)) & 32'hFF)});
            model_mem[a[9:0]] = 8'((wdata >> (8 * k)) & 32'hFF);
        end
        check({name, " write count"}, 64'(wr_log.size() - start), 64'(n));
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            if (start + k < wr_log.size())
                check({name, " write"}, 64'(wr_log[start + k]), 64'(e));
        end
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic mem_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        bus.mem_req_i      = 1'b1;
        bus.mem_we_i       = we;
        bus.mem_size_i     = size;
        bus.mem_unsigned_i = uns;
        bus.mem_addr_i     = addr;
        bus.mem_wdata_i    = wdata;
        cyc   = -1;
        rdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.mem_done_o) begin
                cyc   = k;
                rdata = bus.mem_rdata_o;
                break;
            end
        end
        bus.mem_req_i = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] addr, output logic [31:0] data, output int cyc);
        @(negedge clk);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        cyc  = -1;
        data = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.if_done_o) begin
                cyc  = k;
                data = bus.if_data_o;
                break;
            end
        end
        bus.if_req_i = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [0:13];

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          start;
        int          kind;
        logic [31:0] ra;
        logic [31:0] rw;
        logic [1:0]  rs;
        logic        ru;

        vecs[0]  = '{1'b0, SIZE_W, 1'b0, 32'h0000_0100, 32'h0,         32'h8433_2211, 6};
        vecs[1]  = '{1'b0, SIZE_B, 1'b0, 32'h0000_0103, 32'h0,         32'hFFFF_FF84, 3};
        vecs[2]  = '{1'b0, SIZE_B, 1'b1, 32'h0000_0103, 32'h0,         32'h0000_0084, 3};
        vecs[3]  = '{1'b0, SIZE_H, 1'b0, 32'h0000_0102, 32'h0,         32'hFFFF_8433, 4};
        vecs[4]  = '{1'b0, SIZE_H, 1'b1, 32'h0000_0102, 32'h0,         32'h0000_8433, 4};
        vecs[5]  = '{1'b0, SIZE_B, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0011, 3};
        vecs[6]  = '{1'b1, SIZE_W, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         5};
        vecs[7]  = '{1'b0, SIZE_W, 1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 6};
        vecs[8]  = '{1'b0, 2'b11,  1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 6};
        vecs[9]  = '{1'b0, SIZE_W, 1'b0, 32'h0000_0301, 32'h0,         32'h00CA_FEF0, 6};
        vecs[10] = '{1'b1, SIZE_B, 1'b0, 32'h0000_0304, 32'h0000_00A5, 32'h0,         2};
        vecs[11] = '{1'b0, SIZE_W, 1'b0, 32'h0000_0301, 32'h0,         32'hA5CA_FEF0, 6};
        vecs[12] = '{1'b0, SIZE_W, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 6};
        vecs[13] = '{1'b0, SIZE_H, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_CCBB, 4};

        // ---------------- reset ----------------
        rst                = 1'b1;
        pre_clr            = 1'b1;
        pre_we             = 1'b0;
        pre_addr           = '0;
        pre_data           = '0;
        bus.if_req_i       = 1'b0;
        bus.if_addr_i      = '0;
        bus.if_flush_i     = 1'b0;
        bus.mem_req_i      = 1'b0;
        bus.mem_we_i       = 1'b0;
        bus.mem_size_i     = '0;
        bus.mem_unsigned_i = 1'b0;
        bus.mem_addr_i     = '0;
        bus.mem_wdata_i    = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        pre_clr = 1'b0;

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h84);
        poke(32'h104, 8'hEF); poke(32'h105, 8'hBE); poke(32'h106, 8'hAD); poke(32'h107, 8'hDE);
        poke(32'h040, 8'h78); poke(32'h041, 8'h56); poke(32'h042, 8'h34); poke(32'h043, 8'h12);
        poke(32'h3FE, 8'hAA); poke(32'h3FF, 8'hBB); poke(32'h000, 8'hCC); poke(32'h001, 8'hDD);

        @(negedge clk);
        check("reset if_done",  64'(bus.if_done_o),  64'd0);
        check("reset if_data",  64'(bus.if_data_o),  64'd0);
        check("reset mem_done", 64'(bus.mem_done_o), 64'd0);
        check("reset mem_rdata",64'(bus.mem_rdata_o),64'd0);
        check("reset ram bus",  64'({bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o}), 64'd0);
        check("reset state",    64'(bus.state_o),    64'(CTRL_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // ---------------- LW at 0x100, cycle by cycle ----------------
        bus.mem_req_i  = 1'b1;  bus.mem_we_i = 1'b0;  bus.mem_size_i = SIZE_W;
        bus.mem_unsigned_i = 1'b0;  bus.mem_addr_i = 32'h100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4)
                check($sformatf("lw addr c%0d", k), 64'({bus.ram_we_o, bus.ram_addr_o}),
                      64'({1'b0, 32'h100 + 32'(k - 1)}));
            check($sformatf("lw done c%0d", k), 64'(bus.mem_done_o), 64'(k == 6));
            if (k == 6) begin
                check("lw data", 64'(bus.mem_rdata_o), 64'h8433_2211);
                bus.mem_req_i = 1'b0;
            end
        end

        // ---------------- table ----------------
        for (int i = 0; i < 14; i++) begin
            start = wr_log.size();
            mem_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, cyc);
            check($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            if (vecs[i].we)
                check_store($sformatf("vec%0d", i), vecs[i].addr, nbytes(vecs[i].size),
                            vecs[i].wdata, start);
            else
                check($sformatf("vec%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        end

        // ---------------- SH 0x1234BEEF at 0x201 ----------------
        @(negedge clk);
        start = wr_log.size();
        bus.mem_req_i = 1'b1;  bus.mem_we_i = 1'b1;  bus.mem_size_i = SIZE_H;
        bus.mem_addr_i = 32'h201;  bus.mem_wdata_i = 32'h1234_BEEF;
        @(negedge clk);
        check("sh c1", 64'({bus.ram_we_o, bus.ram_addr_o, bus.ram_dout_o, bus.mem_done_o}),
              64'({1'b1, 32'h201, 8'hEF, 1'b0}));
        @(negedge clk);
        check("sh c2", 64'({bus.ram_we_o, bus.ram_addr_o, bus.ram_dout_o, bus.mem_done_o}),
              64'({1'b1, 32'h202, 8'hBE, 1'b0}));
        @(negedge clk);
        check("sh c3", 64'({bus.ram_we_o, bus.mem_done_o}), 64'({1'b0, 1'b1}));
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        check_store("sh", 32'h201, 2, 32'h1234_BEEF, start);

        // ---------------- simultaneous IF + MEM ----------------
        @(negedge clk);
        bus.mem_req_i = 1'b1;  bus.mem_we_i = 1'b0;  bus.mem_size_i = SIZE_W;
        bus.mem_addr_i = 32'h100;
        bus.if_req_i  = 1'b1;  bus.if_addr_i = 32'h104;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("arb mem_done c%0d", k), 64'(bus.mem_done_o), 64'(k == 6));
            check($sformatf("arb if_done c%0d", k),  64'(bus.if_done_o),  64'(k == 12));
            if (k >= 7 && k <= 10)
                check($sformatf("arb fetch addr c%0d", k), 64'(bus.ram_addr_o),
                      64'(32'h104 + 32'(k - 7)));
            if (k == 6) begin
                check("arb mem data", 64'(bus.mem_rdata_o), 64'h8433_2211);
                bus.mem_req_i = 1'b0;
            end
            if (k == 8) check("arb mem data held", 64'(bus.mem_rdata_o), 64'h8433_2211);
            if (k == 12) begin
                check("arb if data", 64'(bus.if_data_o), 64'hDEAD_BEEF);
                bus.if_req_i = 1'b0;
            end
        end

        // ---------------- flush in cycle 3 of a fetch ----------------
        @(negedge clk);
        bus.if_req_i = 1'b1;  bus.if_addr_i = 32'h100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) check("flush idle c4", 64'(bus.state_o), 64'(CTRL_IDLE));
            check($sformatf("flush if_done c%0d", k), 64'(bus.if_done_o), 64'(k == 10));
            if (k == 3) bus.if_flush_i = 1'b1;
            if (k == 4) begin
                bus.if_flush_i = 1'b0;
                bus.if_addr_i  = 32'h40;
            end
            if (k == 10) begin
                check("flush new fetch data", 64'(bus.if_data_o), 64'h1234_5678);
                bus.if_req_i = 1'b0;
            end
        end

        // ---------------- reset during cycle 2 of an SW ----------------
        @(negedge clk);
        start = wr_log.size();
        bus.mem_req_i = 1'b1;  bus.mem_we_i = 1'b1;  bus.mem_size_i = SIZE_W;
        bus.mem_addr_i = 32'h380;  bus.mem_wdata_i = 32'hA1B2_C3D4;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst ram bus", 64'({bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o}), 64'd0);
        check("rst done/data", 64'({bus.mem_done_o, bus.mem_rdata_o, bus.if_done_o, bus.if_data_o}), 64'd0);
        check("rst state", 64'(bus.state_o), 64'(CTRL_IDLE));
        rst = 1'b0;
        bus.mem_req_i = 1'b0;
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_done_o) cyc++;
        end
        check("rst no done", 64'(cyc), 64'd0);
        check_store("rst partial", 32'h380, 2, 32'hA1B2_C3D4, start);
        mem_txn(1'b0, SIZE_B, 1'b0, 32'h381, 32'h0, rd, cyc);
        check("post-rst lb cycles", 64'(cyc), 64'd3);
        check("post-rst lb data", 64'(rd), 64'hFFFF_FFC3);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ra   = $urandom_range(0, 1023);
            rw   = $urandom;
            rs   = 2'($urandom_range(0, 3));
            ru   = 1'($urandom_range(0, 1));
            start = wr_log.size();
            if (kind == 3) begin
                if_txn(ra, rd, cyc);
                check($sformatf("rnd%0d fetch cycles", i), 64'(cyc), 64'd6);
                check($sformatf("rnd%0d fetch data", i), 64'(rd), 64'(model_load(ra, SIZE_W, 1'b1)));
            end else if (kind == 2) begin
                mem_txn(1'b1, rs, ru, ra, rw, rd, cyc);
                check($sformatf("rnd%0d store cycles", i), 64'(cyc), 64'(nbytes(rs) + 1));
                check_store($sformatf("rnd%0d", i), ra, nbytes(rs), rw, start);
            end else begin
                mem_txn(1'b0, rs, ru, ra, rw, rd, cyc);
                check($sformatf("rnd%0d load cycles", i), 64'(cyc), 64'(nbytes(rs) + 2));
                check($sformatf("rnd%0d load data", i), 64'(rd), 64'(model_load(ra, rs, ru)));
                check($sformatf("rnd%0d load no write", i), 64'(wr_log.size() - start), 64'd0);
            end
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
